// File: rtl/mux_2to1_arbiter.sv
// Round-robin arbiter sharing one N-bit 2:1 mux between two valid/ready requesters,
// holding a grant per burst (bounded by MAX_BURST) and registering the muxed beat.
module mux_2to1_arbiter #(
    parameter int unsigned N         = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [N-1:0] req0_data,
    input  logic         req0_last,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [N-1:0] req1_data,
    input  logic         req1_last,
    output logic         req1_ready,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    output logic         out_last,
    input  logic         out_ready,
    output logic         sel,
    output logic         en
);

    localparam int unsigned CW = $clog2(MAX_BURST) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           prio;
    logic           prio_nxt;
    logic [CW-1:0]  beat_cnt;
    logic [CW-1:0]  beat_cnt_nxt;
    logic           accept;
    logic [N-1:0]   beat_data;
    logic           beat_last;
    logic           burst_end;

    function automatic state_t arb(input logic v0, input logic v1, input logic p);
        if (v0 && v1) return p ? GRANT1 : GRANT0;
        if (v0)       return GRANT0;
        if (v1)       return GRANT1;
        return IDLE;
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            prio     <= 1'b0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            prio     <= prio_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    // Mux datapath and accept detection; readies are mutually exclusive
    assign beat_data = sel ? req1_data : req0_data;
    assign beat_last = sel ? req1_last : req0_last;
    assign accept    = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign burst_end = beat_last || (beat_cnt == CW'(MAX_BURST - 1));

    // Next-state logic: arbitrate in IDLE or when a grant releases on an accepted beat.
    // A beat accepted with last consumes that requester; a forced release keeps it pending.
    always_comb begin
        state_nxt    = state;
        prio_nxt     = prio;
        beat_cnt_nxt = beat_cnt;
        case (state)
            IDLE: state_nxt = arb(req0_valid, req1_valid, prio);
            GRANT0, GRANT1: begin
                if (accept) begin
                    if (burst_end) begin
                        prio_nxt     = !sel;
                        beat_cnt_nxt = '0;
                        state_nxt    = sel ? arb(req0_valid, !beat_last, 1'b0)
                                           : arb(!beat_last, req1_valid, 1'b1);
                    end else begin
                        beat_cnt_nxt = beat_cnt + CW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from state
    always_comb begin
        sel        = 1'b0;
        en         = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            GRANT0: begin
                en         = 1'b1;
                req0_ready = !out_valid || out_ready;
            end
            GRANT1: begin
                sel        = 1'b1;
                en         = 1'b1;
                req1_ready = !out_valid || out_ready;
            end
            default: ;
        endcase
    end

    // Single output stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= beat_data;
            out_last  <= beat_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_2to1_arbiter.sv
// Directed self-checking bench for mux_2to1_arbiter (N=8, MAX_BURST=4).
module tb_mux_2to1_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_last;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_last;
    logic       req1_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       sel;
    logic       en;

    int total = 0;
    int bad   = 0;

    mux_2to1_arbiter #(.N(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .sel(sel), .en(en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
        req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
        out_ready  = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #3;
        total++;
        if ({out_valid, out_last, sel, en, req0_ready, req1_ready} !== 6'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 000000", {out_valid, out_last, sel, en, req0_ready, req1_ready});
        end
        total++;
        if (out_data !== 8'h00) begin
            bad++; $display("FAIL reset_data: got %0h want 0", out_data);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        tick();
        total++;
        if ({en, req0_ready, req1_ready} !== 3'b000) begin
            bad++; $display("FAIL reset_hold: got %b want 000", {en, req0_ready, req1_ready});
        end
        rst = 1'b0;
        #1;
        total++;
        if ({sel, en, req0_ready} !== 3'b000) begin
            bad++; $display("FAIL idle_no_ready: got %b want 000", {sel, en, req0_ready});
        end
        tick();
        total++;
        if ({sel, en, req0_ready, req1_ready} !== 4'b0110) begin
            bad++; $display("FAIL reset_first_grant: got %b want 0110", {sel, en, req0_ready, req1_ready});
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        out_ready = 1'b0;
        req0_valid = 1'b1; req0_data = 8'h77;
        tick();
        tick();
        total++;
        if ({out_valid, out_data} !== {1'b1, 8'h77}) begin
            bad++; $display("FAIL midrst_loaded: got %b/%0h want 1/77", out_valid, out_data);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({out_valid, out_data, sel, en, req0_ready, req1_ready} !== 13'b0) begin
            bad++; $display("FAIL midrst_async: got v=%b d=%0h sel=%b en=%b r0=%b r1=%b want all 0",
                            out_valid, out_data, sel, en, req0_ready, req1_ready);
        end
        rst = 1'b0;
        req1_valid = 1'b1;
        tick();
        total++;
        if ({sel, en} !== 2'b01) begin
            bad++; $display("FAIL midrst_regrant0: got sel/en %b want 01", {sel, en});
        end
    endtask

    task automatic test_single();
        do_reset();
        req0_valid = 1'b1; req0_data = 8'h11; req0_last = 1'b0;
        tick();
        total++;
        if ({out_valid, sel, en, req0_ready} !== 4'b0011) begin
            bad++; $display("FAIL single_grant: got %b want 0011", {out_valid, sel, en, req0_ready});
        end
        tick();
        req0_data = 8'h22;
        total++;
        if ({out_valid, out_data, out_last, sel} !== {1'b1, 8'h11, 1'b0, 1'b0}) begin
            bad++; $display("FAIL single_b1: got v=%b d=%0h l=%b sel=%b want 1/11/0/0", out_valid, out_data, out_last, sel);
        end
        tick();
        req0_data = 8'h33; req0_last = 1'b1;
        total++;
        if ({out_valid, out_data, out_last} !== {1'b1, 8'h22, 1'b0}) begin
            bad++; $display("FAIL single_b2: got v=%b d=%0h l=%b want 1/22/0", out_valid, out_data, out_last);
        end
        tick();
        req0_valid = 1'b0; req0_last = 1'b0;
        total++;
        if ({out_valid, out_data, out_last, en} !== {1'b1, 8'h33, 1'b1, 1'b0}) begin
            bad++; $display("FAIL single_b3: got v=%b d=%0h l=%b en=%b want 1/33/1/0", out_valid, out_data, out_last, en);
        end
        tick();
        total++;
        if ({out_valid, en} !== 2'b00) begin
            bad++; $display("FAIL single_drain: got v/en %b want 00", {out_valid, en});
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req0_valid = 1'b1; req0_data = 8'hA0; req0_last = 1'b1;
        req1_valid = 1'b1; req1_data = 8'hB0; req1_last = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({sel, en, req0_ready, req1_ready} !== 4'b0110) begin
                bad++; $display("FAIL rr_g0_%0d: got %b want 0110", i, {sel, en, req0_ready, req1_ready});
            end
            if (i > 0) begin
                total++;
                if ({out_valid, out_data} !== {1'b1, 8'(8'hB0 + i - 1)}) begin
                    bad++; $display("FAIL rr_outb_%0d: got %b/%0h want 1/%0h", i, out_valid, out_data, 8'(8'hB0 + i - 1));
                end
            end
            tick();
            req0_data = 8'(8'hA0 + i + 1);
            total++;
            if ({sel, en, req0_ready, req1_ready, out_valid, out_data} !== {4'b1101, 1'b1, 8'(8'hA0 + i)}) begin
                bad++; $display("FAIL rr_g1_%0d: got ctl=%b v=%b d=%0h want 1101/1/%0h", i,
                                {sel, en, req0_ready, req1_ready}, out_valid, out_data, 8'(8'hA0 + i));
            end
            tick();
            req1_data = 8'(8'hB0 + i + 1);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        total++;
        if ({out_valid, out_data} !== {1'b1, 8'hB3}) begin
            bad++; $display("FAIL rr_last: got %b/%0h want 1/b3", out_valid, out_data);
        end
    endtask

    task automatic test_forced_rotation();
        do_reset();
        req0_valid = 1'b1; req0_data = 8'h01; req0_last = 1'b0;
        req1_valid = 1'b1; req1_data = 8'hC1; req1_last = 1'b1;
        tick();
        for (int j = 1; j <= 4; j++) begin
            total++;
            if ({sel, en} !== 2'b01) begin
                bad++; $display("FAIL frc_sel_%0d: got %b want 01", j, {sel, en});
            end
            tick();
            total++;
            if ({out_valid, out_data, out_last} !== {1'b1, 8'(j), 1'b0}) begin
                bad++; $display("FAIL frc_beat_%0d: got v=%b d=%0h l=%b want 1/%0h/0", j, out_valid, out_data, out_last, j);
            end
            req0_data = 8'(j + 1);
            req0_last = (j + 1 == 6);
        end
        total++;
        if ({sel, en, req0_ready, req1_ready} !== 4'b1101) begin
            bad++; $display("FAIL frc_rotate: got %b want 1101", {sel, en, req0_ready, req1_ready});
        end
        tick();
        req1_valid = 1'b0;
        total++;
        if ({out_data, out_last, sel} !== {8'hC1, 1'b1, 1'b0}) begin
            bad++; $display("FAIL frc_req1: got d=%0h l=%b sel=%b want c1/1/0", out_data, out_last, sel);
        end
        tick();
        req0_data = 8'h06; req0_last = 1'b1;
        total++;
        if ({out_data, out_last, sel} !== {8'h05, 1'b0, 1'b0}) begin
            bad++; $display("FAIL frc_b5: got d=%0h l=%b sel=%b want 05/0/0", out_data, out_last, sel);
        end
        tick();
        req0_valid = 1'b0; req0_last = 1'b0;
        total++;
        if ({out_valid, out_data, out_last, en} !== {1'b1, 8'h06, 1'b1, 1'b0}) begin
            bad++; $display("FAIL frc_b6: got v=%b d=%0h l=%b en=%b want 1/06/1/0", out_valid, out_data, out_last, en);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req0_valid = 1'b1; req0_data = 8'h5A; req0_last = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        req0_data = 8'h6B;
        #1;
        for (int k = 0; k < 5; k++) begin
            total++;
            if ({out_valid, out_data, req0_ready} !== {1'b1, 8'h5A, 1'b0}) begin
                bad++; $display("FAIL bp_hold_%0d: got v=%b d=%0h r0=%b want 1/5a/0", k, out_valid, out_data, req0_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (req0_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release_ready: got %b want 1", req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        total++;
        if ({out_valid, out_data} !== {1'b1, 8'h6B}) begin
            bad++; $display("FAIL bp_next: got %b/%0h want 1/6b", out_valid, out_data);
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL bp_drain: got %b want 0", out_valid);
        end
    endtask

    task automatic test_valid_gap();
        do_reset();
        req1_valid = 1'b1; req1_data = 8'hD0; req1_last = 1'b0;
        tick();
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_data = 8'hE0; req0_last = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if ({sel, en, req0_ready} !== 3'b110) begin
                bad++; $display("FAIL gap_hold_%0d: got %b want 110", k, {sel, en, req0_ready});
            end
            tick();
        end
        req1_valid = 1'b1; req1_data = 8'hD1; req1_last = 1'b1;
        #1;
        total++;
        if ({sel, req1_ready} !== 2'b11) begin
            bad++; $display("FAIL gap_resume: got %b want 11", {sel, req1_ready});
        end
        tick();
        req1_valid = 1'b0;
        total++;
        if ({out_valid, out_data, out_last, sel, en} !== {1'b1, 8'hD1, 1'b1, 1'b0, 1'b1}) begin
            bad++; $display("FAIL gap_done: got v=%b d=%0h l=%b sel=%b en=%b want 1/d1/1/0/1",
                            out_valid, out_data, out_last, sel, en);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_reset_mid_burst();
        test_single();
        test_round_robin();
        test_forced_rotation();
        test_backpressure();
        test_valid_gap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_2to1_arbiter.md
Name: mux_2to1_arbiter

Overview:
- Round-robin arbiter that shares one N-bit 2:1 mux datapath between two valid/ready requesters.
- Drives the mux sel/en internally and holds a grant for a whole burst, up to a forced-rotation limit.
- Registers the muxed beat into a single output stage for a downstream valid/ready consumer.
- Sits between two producers (e.g. two register-file read ports or DMA channels) and one shared bus.

Parameters:
N, 8, data width of each requester and the output
MAX_BURST, 4, max beats accepted per grant before forced rotation (>=1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has a beat
req0_data  input  N  requester 0 beat data
req0_last  input  1  last beat of requester 0 burst
req0_ready  output  1  requester 0 beat accepted this cycle when valid&ready
req1_valid  input  1  requester 1 has a beat
req1_data  input  N  requester 1 beat data
req1_last  input  1  last beat of requester 1 burst
req1_ready  output  1  requester 1 beat accepted this cycle when valid&ready
out_valid  output  1  output register holds a beat
out_data  output  N  registered muxed data
out_last  output  1  registered last flag
out_ready  input  1  consumer accepts the output beat
sel  output  1  mux select currently driven (1 = requester 1)
en  output  1  mux enable (1 while a grant is held)

Behaviour:
- Reset (async, immediate):
  - state=IDLE, prio=0 (requester 0 preferred), beat_cnt=0.
  - out_valid=0, out_data=0, out_last=0, sel=0, en=0, req0_ready=req1_ready=0.
  - A beat in flight in the output register is discarded; no partial burst is resumed after reset.
- FSM states: IDLE, GRANT0, GRANT1.
- sel=1 only in GRANT1; en=1 in GRANT0/GRANT1, 0 in IDLE.
- Arbitration (evaluated in IDLE and on a grant release):
  - Only one valid -> grant that requester.
  - Both valid -> grant requester prio.
  - None valid -> IDLE.
- Grant takes effect the next cycle. IDLE never asserts either ready.
- In GRANTk:
  - reqk_ready = !out_valid || out_ready. The other requester's ready = 0.
  - Accept = reqk_valid && reqk_ready. On accept, the output register loads reqk_data/reqk_last next edge, out_valid=1, and beat_cnt increments.
  - Latency from accept to out_valid is exactly 1 cycle. Full throughput: 1 beat/cycle while out_ready=1.
- Release: on an accepted beat with reqk_last=1, or when beat_cnt+1==MAX_BURST.
  - prio <= other requester, beat_cnt <= 0.
  - Next state comes from arbitration on the same cycle's valids, using the updated prio. No bubble cycle between back-to-back grants.
- Forced release with last=0: the burst resumes on a later grant. out_last reflects the requester's flag unchanged.
- Granted requester drops valid mid-burst: grant is held indefinitely (no timeout); beat_cnt unchanged.
- Output register:
  - out_valid clears when out_ready=1 and no new accept occurs that cycle.
  - Simultaneous out_ready and accept -> register reloads, out_valid stays 1.
  - Data/last are stable while out_valid=1 and out_ready=0.
- beat_cnt width = clog2(MAX_BURST)+1. It never exceeds MAX_BURST-1.

Test Plan:
- Reset: assert rst mid-burst with out_valid=1 -> out_valid, out_data, ready, sel, en drop to 0 immediately; after release, req0 is granted first when both are valid.
- Single requester:
  - Stimulus: req0 sends 3 beats 0x11, 0x22, 0x33 (last on 0x33), out_ready=1.
  - Response: out_data 0x11/0x22/0x33 on consecutive cycles, each 1 cycle after accept; sel=0; IDLE afterwards.
- Round-robin:
  - Stimulus: both requesters continuously valid with 1-beat bursts (last=1), data 0xA0+i and 0xB0+i.
  - Response: output alternates A0, B0, A1, B1, … with no idle cycles; sel toggles every cycle.
- Forced rotation:
  - Stimulus: MAX_BURST=4, both valid; req0 sends a 6-beat burst.
  - Response: 4 req0 beats, out_last=0 on beat 4, then a req1 burst, then remaining 2 req0 beats with last on the 6th.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles with a beat 0x5A loaded.
  - Response: out_data holds 0x5A, req0_ready=0 during the stall; on out_ready=1 the next beat is accepted in the same cycle.
- Valid gap: granted req1 drops valid for 3 cycles while req0 is valid -> sel stays 1, req0_ready=0, and the burst resumes without re-arbitration.
